// File: rtl/vga_blit_pkg.sv
// Shared definitions for the VGA blit engine: VRAM geometry, register map,
// CMD/STATUS bit positions, operation codes and FSM state encoding.
package vga_blit_pkg;

  localparam int VRAM_AW = 12;
  localparam int VRAM_DW = 8;

  // Register offsets
  localparam logic [2:0] REG_SRC_LO = 3'd0;
  localparam logic [2:0] REG_SRC_HI = 3'd1;
  localparam logic [2:0] REG_DST_LO = 3'd2;
  localparam logic [2:0] REG_DST_HI = 3'd3;
  localparam logic [2:0] REG_LEN_LO = 3'd4;
  localparam logic [2:0] REG_LEN_HI = 3'd5;
  localparam logic [2:0] REG_FILL   = 3'd6;
  localparam logic [2:0] REG_CMD    = 3'd7;

  // CMD write bits
  localparam int CMD_START_BIT  = 0;
  localparam int CMD_OP_BIT     = 1;
  localparam int CMD_IRQ_EN_BIT = 6;
  localparam int CMD_ABORT_BIT  = 7;

  // STATUS read bits
  localparam int STAT_BUSY_BIT = 7;
  localparam int STAT_DONE_BIT = 6;

  localparam logic OP_FILL = 1'b0;
  localparam logic OP_COPY = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FILL,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE
  } state_e;

  // A copy must run backwards when the destination starts inside the source
  // window above SRC, otherwise not-yet-read source bytes get clobbered.
  function automatic logic copy_descending(input logic [VRAM_AW-1:0] src,
                                           input logic [VRAM_AW-1:0] dst,
                                           input logic [VRAM_AW-1:0] len);
    logic [VRAM_AW:0] src_end;
    src_end = {1'b0, src} + {1'b0, len};
    return (dst > src) && ({1'b0, dst} < src_end);
  endfunction

endpackage

// File: rtl/vga_blit_regs.sv
// Register file of the VGA blit engine: SRC/DST/LEN/FILL storage, START and
// ABORT strobes decoded from CMD writes, the sticky done flag and the
// combinational read mux. Optional irq output under VGA_BLIT_IRQ_EN.
module vga_blit_regs
  import vga_blit_pkg::*;
(
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               reg_sel_i,
  input  logic               reg_we_i,
  input  logic [2:0]         reg_addr_i,
  input  logic [VRAM_DW-1:0] reg_din_i,
  output logic [VRAM_DW-1:0] reg_dout_o,
  input  logic               busy_i,
  input  logic               done_set_i,
  output logic [VRAM_AW-1:0] src_o,
  output logic [VRAM_AW-1:0] dst_o,
  output logic [VRAM_AW-1:0] len_o,
  output logic [VRAM_DW-1:0] fill_o,
  output logic               start_o,
  output logic               op_o,
  output logic               abort_o
`ifdef VGA_BLIT_IRQ_EN
  , output logic             irq_o
`endif
);

  logic [VRAM_AW-1:0] src_q, dst_q, len_q;
  logic [VRAM_DW-1:0] fill_q;
  logic               done_q, done_d;
  logic               cmd_wr, cfg_wr;

  assign cmd_wr = reg_sel_i & reg_we_i & (reg_addr_i == REG_CMD);
  assign cfg_wr = reg_sel_i & reg_we_i & (reg_addr_i != REG_CMD) & ~busy_i;

  // ABORT beats a simultaneous START; START is ignored while busy.
  assign abort_o = cmd_wr & reg_din_i[CMD_ABORT_BIT];
  assign start_o = cmd_wr & reg_din_i[CMD_START_BIT] & ~reg_din_i[CMD_ABORT_BIT] & ~busy_i;
  assign op_o    = reg_din_i[CMD_OP_BIT];

  assign src_o  = src_q;
  assign dst_o  = dst_q;
  assign len_o  = len_q;
  assign fill_o = fill_q;

  // Configuration registers, writable only while no operation is running.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      src_q  <= '0;
      dst_q  <= '0;
      len_q  <= '0;
      fill_q <= '0;
    end else if (cfg_wr) begin
      case (reg_addr_i)
        REG_SRC_LO: src_q[7:0]  <= reg_din_i;
        REG_SRC_HI: src_q[11:8] <= reg_din_i[3:0];
        REG_DST_LO: dst_q[7:0]  <= reg_din_i;
        REG_DST_HI: dst_q[11:8] <= reg_din_i[3:0];
        REG_LEN_LO: len_q[7:0]  <= reg_din_i;
        REG_LEN_HI: len_q[11:8] <= reg_din_i[3:0];
        REG_FILL:   fill_q      <= reg_din_i;
        default: ;
      endcase
    end
  end

  // Sticky done: any CMD write clears it, completion/abort sets it (set wins).
  always_comb begin
    done_d = done_q;
    if (cmd_wr)     done_d = 1'b0;
    if (done_set_i) done_d = 1'b1;
  end

  // Done flag register.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) done_q <= 1'b0;
    else        done_q <= done_d;
  end

`ifdef VGA_BLIT_IRQ_EN
  logic irq_en_q;

  // Interrupt enable follows CMD bit6 on every CMD write.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)      irq_en_q <= 1'b0;
    else if (cmd_wr) irq_en_q <= reg_din_i[CMD_IRQ_EN_BIT];
  end

  assign irq_o = done_q & irq_en_q;
`endif

  // Combinational register read mux.
  always_comb begin
    reg_dout_o = '0;
    case (reg_addr_i)
      REG_SRC_LO: reg_dout_o = src_q[7:0];
      REG_SRC_HI: reg_dout_o = {4'b0000, src_q[11:8]};
      REG_DST_LO: reg_dout_o = dst_q[7:0];
      REG_DST_HI: reg_dout_o = {4'b0000, dst_q[11:8]};
      REG_LEN_LO: reg_dout_o = len_q[7:0];
      REG_LEN_HI: reg_dout_o = {4'b0000, len_q[11:8]};
      REG_FILL:   reg_dout_o = fill_q;
      REG_CMD: begin
        reg_dout_o[STAT_BUSY_BIT] = busy_i;
        reg_dout_o[STAT_DONE_BIT] = done_q;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vga_blit_engine.sv
// VGA blit engine: owns VRAM port A, passes CPU accesses through when idle and
// runs hardware FILL / COPY in the background, stalling the CPU on contention.
// Optional interrupt output enabled by defining VGA_BLIT_IRQ_EN.
module vga_blit_engine
  import vga_blit_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               reg_sel,
  input  logic               reg_we,
  input  logic [2:0]         reg_addr,
  input  logic [VRAM_DW-1:0] reg_din,
  output logic [VRAM_DW-1:0] reg_dout,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [VRAM_AW-1:0] cpu_a,
  input  logic [VRAM_DW-1:0] cpu_din,
  output logic               cpu_wait,
  output logic               vram_we,
  output logic [VRAM_AW-1:0] vram_a,
  output logic [VRAM_DW-1:0] vram_din,
  input  logic [VRAM_DW-1:0] vram_dout,
  output logic               busy
`ifdef VGA_BLIT_IRQ_EN
  , output logic             irq
`endif
);

  logic [VRAM_AW-1:0] src, dst, len;
  logic [VRAM_DW-1:0] fill;
  logic               start, op, abort, done_set;

  state_e             state_q;
  logic [VRAM_AW-1:0] src_q, dst_q, cnt_q;
  logic               desc_q;
  logic [1:0]         wait_q;

  vga_blit_regs u_regs (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .reg_sel_i  (reg_sel),
    .reg_we_i   (reg_we),
    .reg_addr_i (reg_addr),
    .reg_din_i  (reg_din),
    .reg_dout_o (reg_dout),
    .busy_i     (busy),
    .done_set_i (done_set),
    .src_o      (src),
    .dst_o      (dst),
    .len_o      (len),
    .fill_o     (fill),
    .start_o    (start),
    .op_o       (op),
    .abort_o    (abort)
`ifdef VGA_BLIT_IRQ_EN
    , .irq_o    (irq)
`endif
  );

  // DONE is a non-busy state, so CPU accesses already pass through there.
  assign busy = (state_q == ST_FILL) || (state_q == ST_RD) ||
                (state_q == ST_WAIT) || (state_q == ST_WR);
  assign cpu_wait = busy & cpu_req;

  // Blit FSM with working address pointers and remaining-byte counter.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      desc_q  <= 1'b0;
      wait_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          state_q <= ST_IDLE;
          if (start && (len != '0)) begin
            cnt_q <= len;
            if (op == OP_COPY) begin
              state_q <= ST_RD;
              if (copy_descending(src, dst, len)) begin
                desc_q <= 1'b1;
                src_q  <= src + len - 12'd1;
                dst_q  <= dst + len - 12'd1;
              end else begin
                desc_q <= 1'b0;
                src_q  <= src;
                dst_q  <= dst;
              end
            end else begin
              state_q <= ST_FILL;
              dst_q   <= dst;
            end
          end
        end
        ST_FILL: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else begin
            dst_q <= dst_q + 12'd1;
            cnt_q <= cnt_q - 12'd1;
            if (cnt_q == 12'd1) state_q <= ST_DONE;
          end
        end
        ST_RD: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else if (RD_LAT == 1) begin
            state_q <= ST_WR;
          end else begin
            wait_q  <= 2'(RD_LAT - 2);
            state_q <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (abort)               state_q <= ST_IDLE;
          else if (wait_q == 2'd0) state_q <= ST_WR;
          else                     wait_q  <= wait_q - 2'd1;
        end
        ST_WR: begin
          if (abort) begin
            state_q <= ST_IDLE;
          end else begin
            src_q   <= desc_q ? src_q - 12'd1 : src_q + 12'd1;
            dst_q   <= desc_q ? dst_q - 12'd1 : dst_q + 12'd1;
            cnt_q   <= cnt_q - 12'd1;
            state_q <= (cnt_q == 12'd1) ? ST_DONE : ST_RD;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Done is raised on entry to DONE, on abort, and on a zero-length START.
  always_comb begin
    done_set = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: done_set = start && (len == '0);
      ST_FILL, ST_WR:   done_set = abort || (cnt_q == 12'd1);
      ST_RD, ST_WAIT:   done_set = abort;
      default:          done_set = 1'b0;
    endcase
  end

  // VRAM port-A mux: CPU passthrough unless the engine owns the cycle.
  always_comb begin
    vram_we  = cpu_req & cpu_we;
    vram_a   = cpu_a;
    vram_din = cpu_din;
    case (state_q)
      ST_FILL: begin
        vram_we  = 1'b1;
        vram_a   = dst_q;
        vram_din = fill;
      end
      ST_RD, ST_WAIT: begin
        vram_we = 1'b0;
        vram_a  = src_q;
      end
      ST_WR: begin
        vram_we  = 1'b1;
        vram_a   = dst_q;
        vram_din = vram_dout;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_vga_blit_engine.sv
// Directed testbench for vga_blit_engine with a 4 KB VRAM model (read latency 1).
module tb_vga_blit_engine;

  logic        clk_sys = 1'b0;
  logic        rst_n;
  logic        reg_sel, reg_we;
  logic [2:0]  reg_addr;
  logic [7:0]  reg_din, reg_dout;
  logic        cpu_req, cpu_we, cpu_wait;
  logic [11:0] cpu_a;
  logic [7:0]  cpu_din;
  logic        vram_we;
  logic [11:0] vram_a;
  logic [7:0]  vram_din, vram_dout;
  logic        busy;
`ifdef VGA_BLIT_IRQ_EN
  logic        irq;
`endif

  always #5 clk_sys = ~clk_sys;

  vga_blit_engine #(.RD_LAT(1)) dut (
    .clk_sys   (clk_sys),
    .rst_n     (rst_n),
    .reg_sel   (reg_sel),
    .reg_we    (reg_we),
    .reg_addr  (reg_addr),
    .reg_din   (reg_din),
    .reg_dout  (reg_dout),
    .cpu_req   (cpu_req),
    .cpu_we    (cpu_we),
    .cpu_a     (cpu_a),
    .cpu_din   (cpu_din),
    .cpu_wait  (cpu_wait),
    .vram_we   (vram_we),
    .vram_a    (vram_a),
    .vram_din  (vram_din),
    .vram_dout (vram_dout),
    .busy      (busy)
`ifdef VGA_BLIT_IRQ_EN
    , .irq     (irq)
`endif
  );

  // VRAM model with a backdoor write port for preloading
  logic [7:0]  mem [0:4095];
  logic        bd_we = 1'b0;
  logic [11:0] bd_a  = '0;
  logic [7:0]  bd_d  = '0;

  always @(posedge clk_sys) begin
    if (bd_we)        mem[bd_a] <= bd_d;
    else if (vram_we) mem[vram_a] <= vram_din;
    vram_dout <= mem[vram_a];
  end

  // Monitor: logs every VRAM write address and counts busy cycles
  int          we_total   = 0;
  int          busy_total = 0;
  logic [11:0] wlog [0:16383];

  always @(negedge clk_sys) begin
    if (vram_we === 1'b1) begin
      wlog[we_total[13:0]] <= vram_a;
      we_total <= we_total + 1;
    end
    if (busy === 1'b1) busy_total <= busy_total + 1;
  end

  int tests = 0;
  int fails = 0;

  function automatic logic [7:0] pat(input int a);
    return 8'(a * 7 + 3);
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic reg_wr(input logic [2:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    reg_sel = 1'b1; reg_we = 1'b1; reg_addr = a; reg_din = d;
    @(negedge clk_sys);
    reg_sel = 1'b0; reg_we = 1'b0;
  endtask

  task automatic reg_rd(input logic [2:0] a, output logic [7:0] d);
    reg_addr = a;
    #1;
    d = reg_dout;
  endtask

  task automatic set_op(input logic [11:0] s, input logic [11:0] dd, input logic [11:0] l);
    reg_wr(3'd0, s[7:0]);  reg_wr(3'd1, {4'h0, s[11:8]});
    reg_wr(3'd2, dd[7:0]); reg_wr(3'd3, {4'h0, dd[11:8]});
    reg_wr(3'd4, l[7:0]);  reg_wr(3'd5, {4'h0, l[11:8]});
  endtask

  task automatic poke(input logic [11:0] a, input logic [7:0] d);
    @(negedge clk_sys);
    bd_we = 1'b1; bd_a = a; bd_d = d;
    @(negedge clk_sys);
    bd_we = 1'b0;
  endtask

  // Wait until busy falls (bounded), then step into IDLE
  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (busy === 1'b1 && n < budget) begin
      @(negedge clk_sys);
      n++;
    end
    check(tag, 64'(n < budget), 64'd1);
    @(negedge clk_sys);
    #1;
  endtask

  initial begin
    logic [7:0] rd;
    int we0, busy0, bad, n;

    rst_n = 1'b0; reg_sel = 1'b0; reg_we = 1'b0; reg_addr = 3'd0; reg_din = 8'h00;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_a = 12'hABC; cpu_din = 8'h5C;
    tick(3);
    rst_n = 1'b1;
    tick(1);

    // ---- reset state ----
    $display("[TB] reset state");
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_vram_we", 64'(vram_we), 64'd0);
    check("rst_vram_a", 64'(vram_a), 64'hABC);
    check("rst_vram_din", 64'(vram_din), 64'h5C);
    reg_rd(3'd7, rd); check("rst_status", 64'(rd), 64'h00);
    reg_rd(3'd0, rd); check("rst_src_lo", 64'(rd), 64'h00);

    // ---- idle CPU passthrough write ----
    $display("[TB] cpu write 0x3C -> 0x123 while idle");
    @(negedge clk_sys);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 12'h123; cpu_din = 8'h3C;
    #1;
    check("pt_we", 64'(vram_we), 64'd1);
    check("pt_wait", 64'(cpu_wait), 64'd0);
    @(negedge clk_sys);
    cpu_req = 1'b0; cpu_we = 1'b0;
    check("pt_mem", 64'(mem[12'h123]), 64'h3C);

    // ---- register high nibble masking ----
    $display("[TB] SRC_HI write 0xF2");
    reg_wr(3'd1, 8'hF2);
    reg_rd(3'd1, rd); check("src_hi_mask", 64'(rd), 64'h02);

    // ---- FILL DST 0x100 LEN 0x050 FILL 0x20 ----
    $display("[TB] FILL dst=100 len=050 val=20");
    poke(12'h0FF, 8'h00); poke(12'h150, 8'h00);
    set_op(12'h000, 12'h100, 12'h050);
    reg_wr(3'd6, 8'h20);
    #1; we0 = we_total; busy0 = busy_total;
    reg_wr(3'd7, 8'h01);
    wait_idle("fill_timeout", 500);
    check("fill_we_cycles", 64'(we_total - we0), 64'd80);
    check("fill_busy_cycles", 64'(busy_total - busy0), 64'd80);
    check("fill_first_addr", 64'(wlog[14'(we0)]), 64'h100);
    check("fill_last_addr", 64'(wlog[14'(we0 + 79)]), 64'h14F);
    bad = 0;
    for (int i = 'h100; i < 'h150; i++) if (mem[12'(i)] !== 8'h20) bad++;
    check("fill_data", 64'(bad), 64'd0);
    check("fill_below", 64'(mem[12'h0FF]), 64'h00);
    check("fill_above", 64'(mem[12'h150]), 64'h00);
    reg_rd(3'd7, rd); check("fill_status", 64'(rd), 64'h40);

    // ---- COPY ascending: scroll one 80-column row ----
    $display("[TB] COPY src=050 dst=000 len=7B0");
    for (int i = 0; i < 'h800; i++) poke(12'(i), pat(i));
    set_op(12'h050, 12'h000, 12'h7B0);
    #1; we0 = we_total; busy0 = busy_total;
    reg_wr(3'd7, 8'h03);
    wait_idle("copy_timeout", 5000);
    check("copy_busy_cycles", 64'(busy_total - busy0), 64'd3936);
    check("copy_we_cycles", 64'(we_total - we0), 64'h7B0);
    check("copy_first_addr", 64'(wlog[14'(we0)]), 64'h000);
    bad = 0;
    for (int i = 0; i < 'h7B0; i++) if (mem[12'(i)] !== pat(i + 'h50)) bad++;
    check("copy_data", 64'(bad), 64'd0);
    bad = 0;
    for (int i = 'h7B0; i < 'h800; i++) if (mem[12'(i)] !== pat(i)) bad++;
    check("copy_tail", 64'(bad), 64'd0);

    // ---- COPY overlapping, descending ----
    $display("[TB] COPY src=010 dst=012 len=4 (overlap)");
    poke(12'h010, 8'h11); poke(12'h011, 8'h22); poke(12'h012, 8'h33); poke(12'h013, 8'h44);
    set_op(12'h010, 12'h012, 12'h004);
    #1; we0 = we_total;
    reg_wr(3'd7, 8'h03);
    wait_idle("ovl_timeout", 100);
    check("ovl_order", {16'h0, wlog[14'(we0)], wlog[14'(we0 + 1)], wlog[14'(we0 + 2)], wlog[14'(we0 + 3)]},
          64'h0000_015_014_013_012);
    check("ovl_data", 64'({mem[12'h012], mem[12'h013], mem[12'h014], mem[12'h015]}), 64'h11223344);
    check("ovl_src_keep", 64'({mem[12'h010], mem[12'h011]}), 64'h1122);

    // ---- FILL wrap around 0xFFF ----
    $display("[TB] FILL dst=FFE len=4 val=77 (wrap)");
    set_op(12'h000, 12'hFFE, 12'h004);
    reg_wr(3'd6, 8'h77);
    #1; we0 = we_total;
    reg_wr(3'd7, 8'h01);
    wait_idle("wrap_timeout", 100);
    check("wrap_order", {16'h0, wlog[14'(we0)], wlog[14'(we0 + 1)], wlog[14'(we0 + 2)], wlog[14'(we0 + 3)]},
          64'h0000_FFE_FFF_000_001);
    check("wrap_data", 64'({mem[12'hFFE], mem[12'hFFF], mem[12'h000], mem[12'h001]}), 64'h77777777);
    check("wrap_stop", 64'(mem[12'h002]), 64'(pat('h52)));

    // ---- CPU stall during COPY ----
    $display("[TB] COPY src=300 dst=400 len=10 with cpu write 5A -> 200");
    for (int i = 0; i < 16; i++) poke(12'h300 + 12'(i), 8'hA0 + 8'(i));
    poke(12'h200, 8'h00);
    set_op(12'h300, 12'h400, 12'h010);
    reg_wr(3'd7, 8'h03);
    tick(3);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_a = 12'h200; cpu_din = 8'h5A;
    #1;
    bad = 0; n = 0;
    while (cpu_wait === 1'b1 && n < 200) begin
      if (busy !== 1'b1) bad++;
      if (vram_we === 1'b1 && vram_a === 12'h200) bad++;
      @(negedge clk_sys); #1;
      n++;
    end
    check("stall_timeout", 64'(n < 200), 64'd1);
    check("stall_cycles", 64'(n), 64'd29);
    check("stall_leak", 64'(bad), 64'd0);
    check("stall_release_busy", 64'(busy), 64'd0);
    check("stall_release_we", 64'(vram_we), 64'd1);
    check("stall_release_a", 64'(vram_a), 64'h200);
    @(negedge clk_sys);
    cpu_req = 1'b0; cpu_we = 1'b0;
    check("stall_cpu_write", 64'(mem[12'h200]), 64'h5A);
    bad = 0;
    for (int i = 0; i < 16; i++) if (mem[12'h400 + 12'(i)] !== 8'hA0 + 8'(i)) bad++;
    check("stall_copy_data", 64'(bad), 64'd0);

    // ---- ABORT mid-FILL ----
    $display("[TB] FILL dst=600 len=40 val=99, abort after 10 writes");
    for (int i = 0; i < 'h40; i++) poke(12'h600 + 12'(i), 8'hEE);
    set_op(12'h000, 12'h600, 12'h040);
    reg_wr(3'd6, 8'h99);
    #1; we0 = we_total;
    reg_wr(3'd7, 8'h01);
    tick(4);
    reg_wr(3'd6, 8'h11);
    tick(2);
    reg_wr(3'd7, 8'h80);
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_we_cycles", 64'(we_total - we0), 64'd10);
    reg_rd(3'd7, rd); check("abort_status", 64'(rd), 64'h40);
    check("abort_last_written", 64'(mem[12'h609]), 64'h99);
    check("abort_first_unwritten", 64'(mem[12'h60A]), 64'hEE);
    check("abort_end_unwritten", 64'(mem[12'h63F]), 64'hEE);
    reg_rd(3'd6, rd); check("busy_write_ignored", 64'(rd), 64'h99);
    reg_rd(3'd4, rd); check("abort_len_kept", 64'(rd), 64'h40);
    reg_rd(3'd3, rd); check("abort_dst_kept", 64'(rd), 64'h06);

    // ---- LEN 0 ----
    $display("[TB] START with len=0");
    set_op(12'h000, 12'h700, 12'h000);
    reg_wr(3'd7, 8'h00);
    reg_rd(3'd7, rd); check("cmd_clears_done", 64'(rd), 64'h00);
    #1; we0 = we_total; busy0 = busy_total;
    reg_wr(3'd7, 8'h01);
    reg_rd(3'd7, rd); check("len0_status", 64'(rd), 64'h40);
    tick(3); #1;
    check("len0_no_we", 64'(we_total - we0), 64'd0);
    check("len0_no_busy", 64'(busy_total - busy0), 64'd0);

    // ---- simultaneous START + ABORT ----
    $display("[TB] START+ABORT together, len=4");
    reg_wr(3'd4, 8'h04);
    #1; we0 = we_total; busy0 = busy_total;
    reg_wr(3'd7, 8'h81);
    tick(3); #1;
    check("sa_no_busy", 64'(busy_total - busy0), 64'd0);
    check("sa_no_we", 64'(we_total - we0), 64'd0);

    // ---- asynchronous reset mid-COPY ----
    $display("[TB] COPY src=000 dst=800 len=100, reset mid-way");
    set_op(12'h000, 12'h800, 12'h100);
    cpu_a = 12'h3C3; cpu_din = 8'hC3;
    reg_wr(3'd7, 8'h03);
    tick(10);
    check("pre_reset_busy", 64'(busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_vram_we", 64'(vram_we), 64'd0);
    check("arst_vram_a", 64'(vram_a), 64'h3C3);
    check("arst_vram_din", 64'(vram_din), 64'hC3);
    reg_rd(3'd7, rd); check("arst_status", 64'(rd), 64'h00);
    reg_rd(3'd0, rd); check("arst_src_lo", 64'(rd), 64'h00);
    we0 = we_total;
    tick(3);
    rst_n = 1'b1;
    tick(2); #1;
    check("arst_no_writes", 64'(we_total - we0), 64'd0);
    check("arst_stays_idle", 64'(busy), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
